// File: rtl/reg_access_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_access_sequencer_pkg
//  Purpose  : Shared opcodes, FSM states and instruction field positions for
//             the register-access sequencer and its ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_access_sequencer_pkg;

  // Instruction word layout: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
  // The 8-bit immediate of LDI overlays the rs1/rs2 fields.
  localparam int INSTR_W    = 16;
  localparam int OPC_W      = 4;
  localparam int F_OP_LSB   = 12;
  localparam int F_RD_LSB   = 8;
  localparam int F_RS1_LSB  = 4;
  localparam int F_RS2_LSB  = 0;
  localparam int F_IMM_LSB  = 0;
  localparam int F_IMM_W    = 8;

  localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPC_W-1:0] OP_LDI = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
  localparam logic [OPC_W-1:0] OP_AND = 4'd4;
  localparam logic [OPC_W-1:0] OP_OR  = 4'd5;
  localparam logic [OPC_W-1:0] OP_XOR = 4'd6;
  localparam logic [OPC_W-1:0] OP_SHL = 4'd7;
  localparam logic [OPC_W-1:0] OP_SHR = 4'd8;
  localparam logic [OPC_W-1:0] OP_MOV = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Opcodes that need the register-read and execute steps (ADD..MOV).
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_access_sequencer_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : reg_access_sequencer_alu_core
//  Purpose  : Combinational ALU: (op, a, b) -> (y, c). Modulo arithmetic,
//             shifts by >= DATA_W yield zero.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_access_sequencer_alu_core
  import reg_access_sequencer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [OPC_W-1:0]  i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y,
  output logic              o_c
);

  localparam int              SH_W        = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] c_sh_limit = DATA_W'(DATA_W);

  logic [DATA_W:0] w_sum;
  logic            w_sh_over;

  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  // The whole of b is the shift amount, so any value >= DATA_W clears the result.
  assign w_sh_over = (i_b >= c_sh_limit);

  // Result and carry select; carry is only meaningful for ADD/SUB.
  always_comb begin
    o_y = '0;
    o_c = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_y = w_sum[DATA_W-1:0];
        o_c = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_y = i_a - i_b;
        o_c = (i_a >= i_b);
      end
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_SHL: o_y = w_sh_over ? '0 : (i_a << i_b[SH_W-1:0]);
      OP_SHR: o_y = w_sh_over ? '0 : (i_a >> i_b[SH_W-1:0]);
      OP_MOV: o_y = i_a;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reg_access_sequencer
//  Purpose  : Multi-cycle instruction sequencer driving a 16x16 register
//             file: IDLE -> READ -> EXEC -> WRITE, with LDI/NOP skipping
//             straight to WRITE and undefined opcodes dropped in IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_access_sequencer
  import reg_access_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_instr_valid,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_instr_ready,
  output logic               o_regWrite,
  output logic [ADDR_W-1:0]  o_write_reg_addr,
  output logic [DATA_W-1:0]  o_write_data,
  output logic [ADDR_W-1:0]  o_read_reg_addr_1,
  output logic [ADDR_W-1:0]  o_read_reg_addr_2,
  input  logic [DATA_W-1:0]  i_read_data_1,
  input  logic [DATA_W-1:0]  i_read_data_2,
  output logic               o_done,
  output logic               o_illegal,
  output logic               o_flag_z,
  output logic               o_flag_c
);

  state_t             r_state;
  state_t             w_next_state;
  logic [OPC_W-1:0]   r_op;
  logic [ADDR_W-1:0]  r_rd;
  logic [ADDR_W-1:0]  r_raddr1;
  logic [ADDR_W-1:0]  r_raddr2;
  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;
  logic [DATA_W-1:0]  r_result;
  logic               r_flag_z;
  logic               r_flag_c;
  logic               r_illegal;

  logic               w_accept;
  logic [OPC_W-1:0]   w_in_op;
  logic [F_IMM_W-1:0] w_imm;
  logic [DATA_W-1:0]  w_alu_y;
  logic               w_alu_c;

  assign w_in_op  = i_instr[F_OP_LSB +: OPC_W];
  assign w_imm    = i_instr[F_IMM_LSB +: F_IMM_W];
  assign w_accept = i_instr_valid && (r_state == S_IDLE);

  reg_access_sequencer_alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op (r_op),
    .i_a  (r_op_a),
    .i_b  (r_op_b),
    .o_y  (w_alu_y),
    .o_c  (w_alu_c)
  );

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    w_next_state  = r_state;
    o_instr_ready = 1'b0;
    o_regWrite    = 1'b0;
    o_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_instr_ready = 1'b1;
        if (i_instr_valid) begin
          if ((w_in_op == OP_NOP) || (w_in_op == OP_LDI)) w_next_state = S_WRITE;
          else if (is_alu_op(w_in_op))                    w_next_state = S_READ;
        end
      end
      S_READ:  w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WRITE;
      S_WRITE: begin
        o_done       = 1'b1;
        o_regWrite   = (r_op != OP_NOP);
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Instruction capture, operand/result registers, flags and the illegal pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_raddr1  <= '0;
      r_raddr2  <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_result  <= '0;
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if (w_accept) begin
        r_op <= w_in_op;
        r_rd <= i_instr[F_RD_LSB +: ADDR_W];
        if (w_in_op == OP_LDI) begin
          // LDI has no execute step, so its result and Z flag land at capture.
          r_result <= DATA_W'(w_imm);
          r_flag_z <= (w_imm == '0);
        end else if (is_alu_op(w_in_op)) begin
          // Read addresses only move for ops that read; they hold otherwise.
          r_raddr1 <= i_instr[F_RS1_LSB +: ADDR_W];
          r_raddr2 <= i_instr[F_RS2_LSB +: ADDR_W];
        end else if (w_in_op != OP_NOP) begin
          r_illegal <= 1'b1;
        end
      end
      if (r_state == S_READ) begin
        r_op_a <= i_read_data_1;
        r_op_b <= i_read_data_2;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_alu_y;
        r_flag_z <= (w_alu_y == '0);
        if ((r_op == OP_ADD) || (r_op == OP_SUB)) r_flag_c <= w_alu_c;
      end
    end
  end

  assign o_write_reg_addr  = r_rd;
  assign o_write_data      = r_result;
  assign o_read_reg_addr_1 = r_raddr1;
  assign o_read_reg_addr_2 = r_raddr2;
  assign o_illegal         = r_illegal;
  assign o_flag_z          = r_flag_z;
  assign o_flag_c          = r_flag_c;

endmodule
`default_nettype wire
